// File: rtl/vga_fb_ctrl_if.sv
// Framebuffer write port: valid/ready pixel write from the CPU/DMA side.
interface vga_fb_ctrl_if #(
   parameter int FB_XW = 9,
   parameter int FB_YW = 9
);
   logic             wr_valid;
   logic             wr_ready;
   logic [FB_XW-1:0] wr_x;
   logic [FB_YW-1:0] wr_y;
   logic [23:0]      wr_data;

   modport master (output wr_valid, wr_x, wr_y, wr_data, input wr_ready);
   modport slave  (input wr_valid, wr_x, wr_y, wr_data, output wr_ready);
endinterface

// File: rtl/vga_fb_ctrl.sv
// VGA timing generator with a read-first on-chip framebuffer and a
// valid/ready write port; 2-pixel pipeline from counters to pins.
module vga_fb_ctrl #(
   parameter int H_ACTIVE      = 640,
   parameter int H_FP          = 16,
   parameter int H_SYNC        = 96,
   parameter int H_BP          = 48,
   parameter int V_ACTIVE      = 480,
   parameter int V_FP          = 10,
   parameter int V_SYNC        = 2,
   parameter int V_BP          = 33,
   parameter bit HS_POL        = 1'b0,
   parameter bit VS_POL        = 1'b0,
   parameter int FB_XW         = 9,
   parameter int FB_YW         = 9,
   parameter int FB_W          = 320,
   parameter int FB_H          = 240,
   parameter int DIV           = 2,
   parameter bit WR_BLANK_ONLY = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         mode,
   input  logic [23:0]        bg_rgb,
   vga_fb_ctrl_if.slave       wr,
   output logic               vga_clk,
   output logic               vga_hs,
   output logic               vga_vs,
   output logic               vga_blank_n,
   output logic               vga_sync_n,
   output logic [7:0]         vga_r,
   output logic [7:0]         vga_g,
   output logic [7:0]         vga_b,
   output logic               frame_start,
   output logic [9:0]         addr_h,
   output logic [9:0]         addr_v
);
   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW    = $clog2(DIV);
   localparam int AW    = FB_XW + FB_YW;

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);
   localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
   localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
   localparam logic [9:0] FBW_C  = 10'(FB_W);
   localparam logic [9:0] FBH_C  = 10'(FB_H);
   localparam logic [9:0] BAR_C  = 10'(H_ACTIVE / 8);

   logic [DW-1:0] div_cnt;
   logic          pe;
   logic [9:0]    h_cnt, v_cnt, h_next, v_next;
   logic [1:0]    mode_q;

   assign pe         = (div_cnt == DIV_LAST);
   assign vga_clk    = !rst && (div_cnt < DIV_HALF);
   assign vga_sync_n = 1'b0;
   assign addr_h     = h_cnt;
   assign addr_v     = v_cnt;

   always_comb begin
      h_next = h_cnt;
      v_next = v_cnt;
      if (pe) begin
         if (h_cnt == H_LAST) begin
            h_next = '0;
            v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
         end else begin
            h_next = h_cnt + 10'd1;
         end
      end
   end

   // wr_ready is registered from next-state so it tracks v_cnt exactly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt     <= '0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         frame_start <= 1'b0;
         mode_q      <= '0;
         wr.wr_ready <= 1'b0;
      end else begin
         div_cnt     <= pe ? '0 : div_cnt + DW'(1);
         h_cnt       <= h_next;
         v_cnt       <= v_next;
         frame_start <= pe && (h_cnt == H_LAST) && (v_cnt == V_LAST);
         wr.wr_ready <= WR_BLANK_ONLY ? (v_next >= V_VIS) : 1'b1;
         if (frame_start)
            mode_q <= mode;
      end
   end

   // S0: framebuffer coordinate and RAM read
   logic [9:0]    fx, fy;
   logic [AW-1:0] rd_addr;
   logic          in_fb;
   logic [23:0]   rd_data;
   logic [23:0]   mem [0:(1 << AW) - 1];
   logic          wr_fire;

   always_comb begin
      fx      = (mode_q == 2'd1) ? {1'b0, h_cnt[9:1]} : h_cnt;
      fy      = (mode_q == 2'd1) ? {1'b0, v_cnt[9:1]} : v_cnt;
      in_fb   = (fx < FBW_C) && (fy < FBH_C);
      rd_addr = {fy[FB_YW-1:0], fx[FB_XW-1:0]};
   end

   assign wr_fire = wr.wr_valid && wr.wr_ready &&
                    (32'(wr.wr_x) < FB_W) && (32'(wr.wr_y) < FB_H);

   // read-first: the read samples the old word when addresses collide
   always_ff @(posedge clk) begin
      if (pe)
         rd_data <= mem[rd_addr];
      if (wr_fire)
         mem[{wr.wr_y, wr.wr_x}] <= wr.wr_data;
   end

   logic       s1_vis, s1_hs, s1_vs, s1_in;
   logic [1:0] s1_mode;
   logic [2:0] s1_bar;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vis  <= 1'b0;
         s1_hs   <= 1'b0;
         s1_vs   <= 1'b0;
         s1_in   <= 1'b0;
         s1_mode <= '0;
         s1_bar  <= '0;
      end else if (pe) begin
         s1_vis  <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
         s1_hs   <= (h_cnt >= HS_BEG) && (h_cnt < HS_END);
         s1_vs   <= (v_cnt >= VS_BEG) && (v_cnt < VS_END);
         s1_in   <= in_fb;
         s1_mode <= mode_q;
         s1_bar  <= 3'(h_cnt / BAR_C);
      end
   end

   // S1: colour select
   logic [23:0] colour;

   always_comb begin
      colour = bg_rgb;
      case (s1_mode)
         2'd0, 2'd1: if (s1_in) colour = rd_data;
         2'd2:       colour = {{8{s1_bar[2]}}, {8{s1_bar[1]}}, {8{s1_bar[0]}}};
         default:    colour = bg_rgb;
      endcase
      if (!s1_vis)
         colour = '0;
   end

   // S2: pin registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         vga_hs      <= !HS_POL;
         vga_vs      <= !VS_POL;
         vga_blank_n <= 1'b0;
      end else if (pe) begin
         {vga_r, vga_g, vga_b} <= colour;
         vga_hs      <= s1_hs ? HS_POL : !HS_POL;
         vga_vs      <= s1_vs ? VS_POL : !VS_POL;
         vga_blank_n <= s1_vis;
      end
   end
endmodule
